// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    localparam int ZERO_REG_IDX = 31;
    localparam int SB_RD_W      = 5;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_write;
        logic               mem_read;
        logic               set_flags;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard bus; perf counters present with PIPE_HAZARD_PERF_EN
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5
`ifdef PIPE_HAZARD_PERF_EN
    , parameter int CNT_W = 16
`endif
);
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_set_flags;
    logic             id_flag_use;
    logic             ex_br_taken;

    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [1:0]       hz_state;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_flag_use, ex_br_taken,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, hz_state, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_flag_use, ex_br_taken,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, hz_state, stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_flag_use, ex_br_taken,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, hz_state
    );
    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_flag_use, ex_br_taken,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, hz_state
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// rtl/pipe_hazard_ctrl_scoreboard.sv - shadow EX/MEM entries with bubble insertion
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRd,
    input  logic             idRegWrite,
    input  logic             idMemRead,
    input  logic             idSetFlags,
    output sb_entry_t        exEntry,
    output sb_entry_t        memEntry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            exEntry  <= '0;
            memEntry <= '0;
        end else begin
            if (bubble) begin
                exEntry <= '0;
            end else begin
                exEntry.valid     <= idValid;
                exEntry.rd        <= SB_RD_W'(idRd);
                exEntry.reg_write <= idRegWrite;
                exEntry.mem_read  <= idMemRead;
                exEntry.set_flags <= idSetFlags;
            end
            memEntry <= exEntry;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/flag-use stall and taken-branch flush control (PIPE_HAZARD_PERF_EN adds counters)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int ZERO_REG  = ZERO_REG_IDX,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
    localparam logic [REG_W-1:0] ZERO_IDX     = REG_W'(ZERO_REG);

    if (FLUSH_CYC < 1 || FLUSH_CYC > 3 || CNT_W < 1) begin : gBadParam
        $error("pipe_hazard_ctrl: FLUSH_CYC must be 1..3 and CNT_W at least 1");
    end

    hz_state_t        state, stateNext;
    logic [1:0]       flushCnt, flushCntNext;
    sb_entry_t        exEntry, memEntry;
    logic [REG_W-1:0] exRd;
    logic             rnHit, rmHit, loadHz, flagHz;
    logic             pcWe, ifIdWe, flush, bubble, stallStart;
    logic             unusedOk;

    hazard_scoreboard #(.REG_W(REG_W)) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .bubble     (bubble),
        .idValid    (bus.id_valid),
        .idRd       (bus.id_rd),
        .idRegWrite (bus.id_reg_write),
        .idMemRead  (bus.id_mem_read),
        .idSetFlags (bus.id_set_flags),
        .exEntry    (exEntry),
        .memEntry   (memEntry)
    );

    // MEM results are forwarded, so only the EX entry can force a stall.
    assign unusedOk = ^{memEntry, exEntry.reg_write};

    assign exRd   = REG_W'(exEntry.rd);
    assign rnHit  = bus.id_uses_rn && (bus.id_rn == exRd);
    assign rmHit  = bus.id_uses_rm && (bus.id_rm == exRd);
    assign loadHz = bus.id_valid && exEntry.valid && exEntry.mem_read &&
                    (exRd != ZERO_IDX) && (rnHit || rmHit);
    assign flagHz = bus.id_valid && exEntry.valid && bus.id_flag_use && exEntry.set_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HZ_RUN;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
        end
    end

    // A taken branch outranks every hazard and restarts the flush window.
    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        pcWe         = 1'b1;
        ifIdWe       = 1'b1;
        flush        = 1'b0;
        bubble       = 1'b0;
        stallStart   = 1'b0;
        if (bus.ex_br_taken) begin
            flush        = 1'b1;
            bubble       = 1'b1;
            flushCntNext = FLUSH_RELOAD;
            stateNext    = (FLUSH_CYC > 1) ? HZ_FLUSH : HZ_RUN;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (loadHz || flagHz) begin
                        pcWe       = 1'b0;
                        ifIdWe     = 1'b0;
                        bubble     = 1'b1;
                        stallStart = 1'b1;
                        stateNext  = HZ_STALL;
                    end
                end
                HZ_STALL: stateNext = HZ_RUN;
                HZ_FLUSH: begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                    if (flushCnt <= 2'd1) begin
                        stateNext = HZ_RUN;
                    end else begin
                        flushCntNext = flushCnt - 2'd1;
                    end
                end
                default: stateNext = HZ_RUN;
            endcase
        end
    end

    assign bus.pc_we        = pcWe;
    assign bus.if_id_we     = ifIdWe;
    assign bus.if_id_flush  = flush;
    assign bus.id_ex_bubble = bubble;
    assign bus.hz_state     = state;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCnt, flushCntPerf;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt     <= '0;
            flushCntPerf <= '0;
        end else begin
            if (stallStart && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (bus.ex_br_taken && (flushCntPerf != '1)) begin
                flushCntPerf <= flushCntPerf + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stallCnt;
    assign bus.flush_cnt = flushCntPerf;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, corner sequences and random checks against a reference model
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] rn;
        logic       usesRn;
        logic [4:0] rm;
        logic       usesRm;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
        logic       setFlags;
        logic       flagUse;
        logic       br;
    } inp_t;

    typedef struct packed {
        logic       pcWe;
        logic       ifIdWe;
        logic       flush;
        logic       bubble;
        logic [1:0] state;
    } out_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       memRead;
        logic       setFlags;
    } mEnt_t;

    typedef struct {
        inp_t  i;
        out_t  e;
        string n;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef PIPE_HAZARD_PERF_EN
    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) busA();
    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) busB();
`else
    pipe_hazard_ctrl_if #(.REG_W(5)) busA();
    pipe_hazard_ctrl_if #(.REG_W(5)) busB();
`endif

    pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYC(1), .CNT_W(4)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    pipe_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FLUSH_CYC(3), .CNT_W(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    int checks = 0;
    int errors = 0;

    int    flushLeft [2];
    bit    inStall   [2];
    mEnt_t mEx       [2];
    int    fcOf      [2] = '{1, 3};
    int    mStallCnt = 0;
    int    mFlushCnt = 0;
    out_t  mA, mB;

    vec_t  tab[$];

    function automatic inp_t inp(bit v, int rn, bit urn, int rm, bit urm, int rd,
                                 bit rw, bit mr, bit sf, bit fu, bit br);
        inp_t x;
        x.valid = v; x.rn = 5'(rn); x.usesRn = urn; x.rm = 5'(rm); x.usesRm = urm;
        x.rd = 5'(rd); x.regWrite = rw; x.memRead = mr; x.setFlags = sf;
        x.flagUse = fu; x.br = br;
        return x;
    endfunction

    function automatic out_t outv(bit pc, bit ifid, bit fl, bit bub, int st);
        out_t o;
        o.pcWe = pc; o.ifIdWe = ifid; o.flush = fl; o.bubble = bub; o.state = 2'(st);
        return o;
    endfunction

    function automatic inp_t idle();
        return inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic inp_t ldur(int rd, int rn);
        return inp(1, rn, 1, 0, 0, rd, 1, 1, 0, 0, 0);
    endfunction

    function automatic inp_t alu(int rn, bit urn, int rm, bit urm, int rd, bit sf);
        return inp(1, rn, urn, rm, urm, rd, 1, 0, sf, 0, 0);
    endfunction

    function automatic inp_t bcond();
        return inp(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    function automatic out_t outA();
        return outv(busA.pc_we, busA.if_id_we, busA.if_id_flush, busA.id_ex_bubble, int'(busA.hz_state));
    endfunction

    function automatic out_t outB();
        return outv(busB.pc_we, busB.if_id_we, busB.if_id_flush, busB.id_ex_bubble, int'(busB.hz_state));
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc_we,if_id_we,flush,bubble,state=%b required %b", nm, act, exp);
        end
    endtask

    task automatic checkVal(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            flushLeft[k] = 0;
            inStall[k]   = 1'b0;
            mEx[k]       = '0;
        end
        mStallCnt = 0;
        mFlushCnt = 0;
    endtask

    // Stall when the instruction in EX is a real load writing a register ID reads,
    // or sets the flags a B.cond in ID needs; a taken branch always wins.
    task automatic modelCycle(input int k, input inp_t x, output out_t e);
        bit hz;
        bit bub;
        int st;
        hz = x.valid && mEx[k].valid &&
             ((mEx[k].memRead && mEx[k].rd != 5'd31 &&
               ((x.usesRn && x.rn == mEx[k].rd) || (x.usesRm && x.rm == mEx[k].rd))) ||
              (x.flagUse && mEx[k].setFlags));
        st  = (flushLeft[k] > 0) ? 2 : (inStall[k] ? 1 : 0);
        bub = 1'b0;
        if (x.br) begin
            e = outv(1, 1, 1, 1, st);
            flushLeft[k] = fcOf[k] - 1;
            inStall[k] = 1'b0;
            bub = 1'b1;
            if (k == 0 && mFlushCnt < 15) mFlushCnt++;
        end else if (flushLeft[k] > 0) begin
            e = outv(1, 1, 1, 1, st);
            flushLeft[k]--;
            bub = 1'b1;
        end else if (inStall[k]) begin
            e = outv(1, 1, 0, 0, st);
            inStall[k] = 1'b0;
        end else if (hz) begin
            e = outv(0, 0, 0, 1, st);
            inStall[k] = 1'b1;
            bub = 1'b1;
            if (k == 0 && mStallCnt < 15) mStallCnt++;
        end else begin
            e = outv(1, 1, 0, 0, st);
        end
        if (bub) mEx[k] = '0;
        else     mEx[k] = '{x.valid, x.rd, x.memRead, x.setFlags};
    endtask

    task automatic drive(input inp_t x);
        busA.id_valid = x.valid;     busB.id_valid = x.valid;
        busA.id_rn = x.rn;           busB.id_rn = x.rn;
        busA.id_uses_rn = x.usesRn;  busB.id_uses_rn = x.usesRn;
        busA.id_rm = x.rm;           busB.id_rm = x.rm;
        busA.id_uses_rm = x.usesRm;  busB.id_uses_rm = x.usesRm;
        busA.id_rd = x.rd;           busB.id_rd = x.rd;
        busA.id_reg_write = x.regWrite; busB.id_reg_write = x.regWrite;
        busA.id_mem_read = x.memRead;   busB.id_mem_read = x.memRead;
        busA.id_set_flags = x.setFlags; busB.id_set_flags = x.setFlags;
        busA.id_flag_use = x.flagUse;   busB.id_flag_use = x.flagUse;
        busA.ex_br_taken = x.br;        busB.ex_br_taken = x.br;
    endtask

    // Inputs change mid low phase; outputs are compared before the next rising edge.
    task automatic put(input inp_t x, input bit r);
        @(negedge clk);
        rst = r;
        drive(x);
        #1;
        if (r) modelReset();
        else begin
            modelCycle(0, x, mA);
            modelCycle(1, x, mB);
        end
    endtask

    function automatic int randReg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r;
    endfunction

    initial begin
        inp_t x;
        bit   r;

        drive(idle());
        modelReset();

        tab.push_back('{idle(),                          outv(1,1,0,0,0), "reset_state"});
        tab.push_back('{ldur(2, 3),                      outv(1,1,0,0,0), "ldur_x2"});
        tab.push_back('{alu(2,1,5,0,4,1),                outv(0,0,0,1,0), "load_use_stall"});
        tab.push_back('{alu(2,1,5,0,4,1),                outv(1,1,0,0,1), "load_use_release"});
        tab.push_back('{idle(),                          outv(1,1,0,0,0), "load_use_done"});
        tab.push_back('{ldur(31, 1),                     outv(1,1,0,0,0), "ldur_xzr"});
        tab.push_back('{alu(31,1,31,1,6,0),              outv(1,1,0,0,0), "xzr_no_stall"});
        tab.push_back('{alu(1,1,2,1,5,1),                outv(1,1,0,0,0), "subs"});
        tab.push_back('{bcond(),                         outv(0,0,0,1,0), "flag_stall"});
        tab.push_back('{bcond(),                         outv(1,1,0,0,1), "flag_release"});
        tab.push_back('{alu(1,1,2,1,6,1),                outv(1,1,0,0,0), "adds"});
        tab.push_back('{idle(),                          outv(1,1,0,0,0), "nop"});
        tab.push_back('{bcond(),                         outv(1,1,0,0,0), "flag_gap_no_stall"});
        tab.push_back('{ldur(7, 1),                      outv(1,1,0,0,0), "ldur_x7"});
        tab.push_back('{inp(1,0,0,7,1,8,1,0,0,0,1),      outv(1,1,1,1,0), "branch_beats_load"});
        tab.push_back('{alu(7,1,0,0,9,0),                outv(1,1,0,0,0), "after_flush"});
        tab.push_back('{inp(1,1,1,0,0,8,1,1,1,0,0),      outv(1,1,0,0,0), "load_and_flags"});
        tab.push_back('{inp(1,8,1,0,0,0,0,0,0,1,0),      outv(0,0,0,1,0), "dual_hazard_stall"});
        tab.push_back('{inp(1,8,1,0,0,0,0,0,0,1,0),      outv(1,1,0,0,1), "dual_hazard_release"});
        tab.push_back('{ldur(9, 1),                      outv(1,1,0,0,0), "ldur_x9"});
        tab.push_back('{alu(9,0,9,0,1,0),                outv(1,1,0,0,0), "unused_sources"});
        tab.push_back('{ldur(10, 1),                     outv(1,1,0,0,0), "ldur_x10"});
        tab.push_back('{inp(0,10,1,10,1,1,1,0,0,0,0),    outv(1,1,0,0,0), "id_invalid"});
        tab.push_back('{inp(0,0,0,0,0,11,1,1,0,0,0),     outv(1,1,0,0,0), "invalid_load"});
        tab.push_back('{alu(11,1,11,1,2,0),              outv(1,1,0,0,0), "ex_invalid"});

        put(idle(), 1'b1);
        put(idle(), 1'b1);
        for (int k = 0; k < tab.size(); k++) begin
            put(tab[k].i, 1'b0);
            check(tab[k].n, outA(), tab[k].e);
        end

        // Three-cycle flush window on the FLUSH_CYC=3 instance, then a reload inside it.
        put(idle(), 1'b1);
        put(ldur(2, 1), 1'b0);
        put(inp(1,2,1,0,0,3,1,0,0,0,1), 1'b0); check("fc3_branch",     outB(), outv(1,1,1,1,0));
        put(idle(), 1'b0);                     check("fc3_flush_1",    outB(), outv(1,1,1,1,2));
        put(idle(), 1'b0);                     check("fc3_flush_2",    outB(), outv(1,1,1,1,2));
        put(idle(), 1'b0);                     check("fc3_flush_end",  outB(), outv(1,1,0,0,0));
        put(inp(0,0,0,0,0,0,0,0,0,0,1), 1'b0); check("fc3_br2",        outB(), outv(1,1,1,1,0));
        put(idle(), 1'b0);                     check("fc3_br2_flush",  outB(), outv(1,1,1,1,2));
        put(inp(0,0,0,0,0,0,0,0,0,0,1), 1'b0); check("fc3_reload",     outB(), outv(1,1,1,1,2));
        put(idle(), 1'b0);                     check("fc3_reload_1",   outB(), outv(1,1,1,1,2));
        put(idle(), 1'b0);                     check("fc3_reload_2",   outB(), outv(1,1,1,1,2));
        put(idle(), 1'b0);                     check("fc3_reload_end", outB(), outv(1,1,0,0,0));

        // Reset landing on the STALL cycle leaves nothing behind.
        put(ldur(3, 1), 1'b0);
        put(alu(3,1,0,0,4,0), 1'b0);           check("rst_pre_stall",  outA(), outv(0,0,0,1,0));
        put(alu(3,1,0,0,4,0), 1'b1);           check("rst_in_stall",   outA(), outv(1,1,0,0,1));
        put(alu(3,1,0,0,4,0), 1'b0);           check("rst_consumer",   outA(), outv(1,1,0,0,0));

        put(idle(), 1'b1);
        for (int n = 0; n < 600; n++) begin
            x.valid    = ($urandom_range(0, 5) != 0);
            x.rn       = 5'(randReg());
            x.usesRn   = 1'($urandom_range(0, 1));
            x.rm       = 5'(randReg());
            x.usesRm   = 1'($urandom_range(0, 1));
            x.rd       = 5'(randReg());
            x.regWrite = 1'($urandom_range(0, 1));
            x.memRead  = ($urandom_range(0, 2) == 0);
            x.setFlags = ($urandom_range(0, 2) == 0);
            x.flagUse  = ($urandom_range(0, 3) == 0);
            x.br       = ($urandom_range(0, 7) == 0);
            r          = ($urandom_range(0, 63) == 0);
            put(x, r);
            if (!r) begin
                check("rand_fc1", outA(), mA);
                check("rand_fc3", outB(), mB);
            end
        end

`ifdef PIPE_HAZARD_PERF_EN
        put(idle(), 1'b0);
        checkVal("rand_stall_cnt", int'(busA.stall_cnt), mStallCnt);
        checkVal("rand_flush_cnt", int'(busA.flush_cnt), mFlushCnt);
        put(idle(), 1'b1);
        for (int n = 0; n < 20; n++) begin
            put(ldur(2, 1), 1'b0);
            put(alu(2,1,0,0,3,0), 1'b0);
            put(alu(2,1,0,0,3,0), 1'b0);
        end
        put(idle(), 1'b0);
        checkVal("stall_cnt_saturated", int'(busA.stall_cnt), 15);
        put(idle(), 1'b1);
        put(idle(), 1'b0);
        checkVal("stall_cnt_cleared", int'(busA.stall_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage ARM pipeline. It sits beside the ID stage and consumes decoded ID-stage fields plus the EX-stage branch resolution. It keeps its own shadow scoreboard of the instructions in EX and MEM. From these it drives PC/IF_ID write enables, the IF_ID flush and the ID_EX bubble that together resolve load-use, flag-use and taken-branch hazards.

Parameters:
REG_W, 5, register address width
ZERO_REG, 31, XZR index; never creates a dependency
FLUSH_CYC, 1, IF_ID flush cycles after a taken branch (1..3)
CNT_W, 16, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rn  in  REG_W  ID source register Rn
id_rm  in  REG_W  ID source register Rm/Rt (Reg2Loc already applied)
id_uses_rn  in  1  instruction reads Rn
id_uses_rm  in  1  instruction reads Rm/Rt
id_rd  in  REG_W  ID destination register
id_reg_write  in  1  instruction writes Rd
id_mem_read  in  1  instruction is LDUR
id_set_flags  in  1  instruction sets flags (ADDS/SUBS)
id_flag_use  in  1  instruction is B.cond
ex_br_taken  in  1  EX resolved a taken branch (B, BL, BR, B.cond, CBZ) this cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF_ID register write enable
if_id_flush  out  1  zero the IF_ID register next edge
id_ex_bubble  out  1  load a NOP into ID_EX next edge
hz_state  out  2  current FSM state (debug)

Behaviour:
- Timing: one clock; rst is synchronous and active-high.
- Reset values: state=RUN, scoreboard cleared (ex_valid=0, mem_valid=0, rd=0, flags=0). Outputs at reset: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0, hz_state=0.
- Scoreboard:
  - EX entry {valid, rd, reg_write, mem_read, set_flags} loads from the ID inputs each edge when no bubble is issued. When a bubble is issued it loads all zeros.
  - The MEM entry loads from the EX entry every edge.
- load_hz (combinational): id_valid && ex.mem_read && ex.rd!=ZERO_REG && ((id_uses_rn && id_rn==ex.rd) || (id_uses_rm && id_rm==ex.rd)).
- flag_hz (combinational): id_valid && id_flag_use && ex.set_flags. Flags resolve at the end of EX; forwarding covers MEM, so only EX conflicts.
- FSM states (hz_state encoding): RUN=0, STALL=1, FLUSH=2.
- Priority, evaluated every cycle: ex_br_taken > load_hz/flag_hz > normal.
- RUN transitions:
  - ex_br_taken: if_id_flush=1, id_ex_bubble=1, pc_we=1. Go to FLUSH if FLUSH_CYC>1, else stay in RUN.
  - load_hz or flag_hz: pc_we=0, if_id_we=0, id_ex_bubble=1, go to STALL.
  - Otherwise: all enables 1, no bubble, no flush.
- STALL:
  - Lasts exactly one cycle and always returns to RUN; the hazard has cleared because a bubble now occupies EX.
  - If ex_br_taken asserts during STALL, the flush takes effect that same cycle: pc_we=1, if_id_flush=1, id_ex_bubble=1.
- FLUSH:
  - A down-counter asserts if_id_flush and id_ex_bubble for FLUSH_CYC-1 further cycles, then returns to RUN.
  - A new ex_br_taken while in FLUSH reloads the counter.
- Hazard suppression: no hazard is raised against an invalid entry, ZERO_REG, or when id_valid=0.
- Simultaneous load_hz and flag_hz: a single STALL cycle resolves both.
- Reset mid-STALL or mid-FLUSH: the next edge returns to RUN with the scoreboard cleared. No partial stall survives.
- Output timing: all outputs are a combinational function of the registered state and the current inputs. The hazard decision has no latency; the stall lasts exactly one cycle.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined:
  - Adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments once per STALL entry; flush_cnt increments once per taken-branch flush start.
  - Both saturate at all-ones and clear on rst.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - hz_state_t enum {HZ_RUN, HZ_STALL, HZ_FLUSH}.
  - sb_entry_t struct {valid, rd, reg_write, mem_read, set_flags}.
  - Constant ZERO_REG_IDX = 31.
- One natural sub-module, hazard_scoreboard: the EX/MEM shadow registers with bubble insert. It exposes ex/mem entries to the FSM.

Test Plan:
1. LDUR X2 in ID (id_rd=2, id_mem_read=1), next cycle ADDS reading Rn=2 -> exactly one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1, hz_state=1, then RUN with no further stall.
2. LDUR XZR (rd=31), then a consumer with Rn=31 -> no stall; pc_we remains 1.
3. SUBS, then B.cond (id_flag_use=1) -> one stall cycle. ADDS, NOP, B.cond -> no stall.
4. Load-use hazard and ex_br_taken asserted in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_we=1, no STALL entry. Repeat with FLUSH_CYC=3 -> flush held 3 cycles; hz_state sequence 2,2,0.
5. rst asserted while in STALL -> next edge hz_state=0, pc_we=1, scoreboard empty. An immediate consumer of the old rd does not stall.
6. With PIPE_HAZARD_PERF_EN and CNT_W=4: 20 stalls -> stall_cnt=15 (saturated); rst -> 0.
